// File: rtl/cpx_multiply_pipe_if.sv
// cpx_multiply_pipe_if: stream handshake and operand/result bus of the pipelined complex multiplier
interface cpx_multiply_pipe_if #(
   parameter int X_BITS   = 8,
   parameter int Y_BITS   = 8,
   parameter int OUT_BITS = 17
);
   logic                       m_axis_tvalid;
   logic                       s_axis_tready;
   logic signed [X_BITS-1:0]   xi;
   logic signed [X_BITS-1:0]   xq;
   logic signed [Y_BITS-1:0]   yi;
   logic signed [Y_BITS-1:0]   yq;
   logic                       conj;
   logic                       tlast_in;
   logic                       s_axis_tvalid;
   logic                       m_axis_tready;
   logic signed [OUT_BITS-1:0] i_out;
   logic signed [OUT_BITS-1:0] q_out;
   logic                       ovf;
   logic                       tlast_out;
   modport master (
      output m_axis_tvalid, xi, xq, yi, yq, conj, tlast_in, m_axis_tready,
      input  s_axis_tready, s_axis_tvalid, i_out, q_out, ovf, tlast_out
   );
   modport slave (
      input  m_axis_tvalid, xi, xq, yi, yq, conj, tlast_in, m_axis_tready,
      output s_axis_tready, s_axis_tvalid, i_out, q_out, ovf, tlast_out
   );
endinterface

// File: rtl/cpx_multiply_pipe.sv
// cpx_multiply_pipe: 4-stage complex multiplier (x*y or x*conj(y)) with rounding, saturation and stall
module cpx_multiply_pipe #(
   parameter int X_BITS    = 8,
   parameter int Y_BITS    = 8,
   parameter int OUT_BITS  = 17,
   parameter int OUT_SHIFT = 0
) (
   input logic                clk,
   input logic                reset,
   cpx_multiply_pipe_if.slave bus
);
   localparam int P = X_BITS + Y_BITS;
   localparam int F = P + 1;
   localparam int W = (OUT_BITS > F + 1 ? OUT_BITS : F + 1) + 1;
   localparam logic signed [W-1:0] HALF = OUT_SHIFT > 0 ? W'(1) << (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0) : '0;
   localparam logic signed [W-1:0] MAXV = (W'(1) << (OUT_BITS - 1)) - W'(1);
   localparam logic signed [W-1:0] MINV = -MAXV - W'(1);
   logic                       en;
   logic                       v1, v2, v3;
   logic                       c1, c2;
   logic                       t1, t2, t3;
   logic signed [X_BITS-1:0]   xi1, xq1;
   logic signed [Y_BITS-1:0]   yi1, yq1;
   logic signed [P-1:0]        pii, pqq, piq, pqi;
   logic signed [F-1:0]        si, sq;
   logic signed [W-1:0]        ri, rq;
   logic signed [OUT_BITS-1:0] i_n, q_n;
   logic                       oi, oq;
   assign en = !bus.s_axis_tvalid || bus.m_axis_tready;
   assign bus.s_axis_tready = en;
   // round half toward +inf in a width wide enough that neither rounding nor clamping can wrap
   always_comb begin
      ri  = (W'(si) + HALF) >>> OUT_SHIFT;
      rq  = (W'(sq) + HALF) >>> OUT_SHIFT;
      oi  = ri > MAXV || ri < MINV;
      oq  = rq > MAXV || rq < MINV;
      i_n = ri > MAXV ? MAXV[OUT_BITS-1:0] : ri < MINV ? MINV[OUT_BITS-1:0] : ri[OUT_BITS-1:0];
      q_n = rq > MAXV ? MAXV[OUT_BITS-1:0] : rq < MINV ? MINV[OUT_BITS-1:0] : rq[OUT_BITS-1:0];
   end
   // stage valids and output registers; reset flushes every in-flight beat
   always_ff @(posedge clk) begin
      if (reset) begin
         v1                <= 1'b0;
         v2                <= 1'b0;
         v3                <= 1'b0;
         bus.s_axis_tvalid <= 1'b0;
         bus.i_out         <= '0;
         bus.q_out         <= '0;
         bus.ovf           <= 1'b0;
         bus.tlast_out     <= 1'b0;
      end else if (en) begin
         v1                <= bus.m_axis_tvalid;
         v2                <= v1;
         v3                <= v2;
         bus.s_axis_tvalid <= v3;
         bus.i_out         <= i_n;
         bus.q_out         <= q_n;
         bus.ovf           <= oi || oq;
         bus.tlast_out     <= t3;
      end
   end
   // datapath: operand capture, four partial products, conj-selected add/sub; conj and tlast ride along
   always_ff @(posedge clk) begin
      if (en) begin
         xi1 <= bus.xi;
         xq1 <= bus.xq;
         yi1 <= bus.yi;
         yq1 <= bus.yq;
         c1  <= bus.conj;
         t1  <= bus.tlast_in;
         pii <= P'(xi1) * P'(yi1);
         pqq <= P'(xq1) * P'(yq1);
         piq <= P'(xi1) * P'(yq1);
         pqi <= P'(xq1) * P'(yi1);
         c2  <= c1;
         t2  <= t1;
         si  <= c2 ? F'(pii) + F'(pqq) : F'(pii) - F'(pqq);
         sq  <= c2 ? F'(pqi) - F'(piq) : F'(piq) + F'(pqi);
         t3  <= t2;
      end
   end
endmodule

// File: tb/tb_cpx_multiply_pipe.sv
// tb_cpx_multiply_pipe: three configurations fed the same stream, scoreboarded against an arithmetic model
module tb_cpx_multiply_pipe;
   typedef struct packed {
      logic signed [31:0] i;
      logic signed [31:0] q;
      logic               ov;
      logic               tl;
   } exp_t;
   localparam int SH [3] = '{0, 0, 4};
   localparam int OB [3] = '{17, 16, 10};
   logic clk, reset, mv, mr, cj, tl, done;
   logic signed [7:0] xi, xq, yi, yq;
   int checks, passed;
   exp_t sb [3][$];
   cpx_multiply_pipe_if #(.OUT_BITS(17)) b0 ();
   cpx_multiply_pipe_if #(.OUT_BITS(16)) b1 ();
   cpx_multiply_pipe_if #(.OUT_BITS(10)) b2 ();
   assign b0.m_axis_tvalid = mv; assign b1.m_axis_tvalid = mv; assign b2.m_axis_tvalid = mv;
   assign b0.m_axis_tready = mr; assign b1.m_axis_tready = mr; assign b2.m_axis_tready = mr;
   assign b0.xi = xi; assign b1.xi = xi; assign b2.xi = xi;
   assign b0.xq = xq; assign b1.xq = xq; assign b2.xq = xq;
   assign b0.yi = yi; assign b1.yi = yi; assign b2.yi = yi;
   assign b0.yq = yq; assign b1.yq = yq; assign b2.yq = yq;
   assign b0.conj = cj; assign b1.conj = cj; assign b2.conj = cj;
   assign b0.tlast_in = tl; assign b1.tlast_in = tl; assign b2.tlast_in = tl;
   cpx_multiply_pipe #(.OUT_BITS(17), .OUT_SHIFT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   cpx_multiply_pipe #(.OUT_BITS(16), .OUT_SHIFT(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   cpx_multiply_pipe #(.OUT_BITS(10), .OUT_SHIFT(4)) dut2 (.clk(clk), .reset(reset), .bus(b2));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask
   function automatic int rnd(input int v, input int sh);
      return int'($floor(real'(v) / real'(2 ** sh) + 0.5));
   endfunction
   function automatic int clamp(input int v, input int ob);
      int m = 2 ** (ob - 1);
      return v > m - 1 ? m - 1 : v < -m ? -m : v;
   endfunction
   function automatic exp_t model(input int a, b, c, e, input logic j, t, input int sh, ob);
      exp_t r;
      int vi, vq, ui, uq;
      vi = j ? a * c + b * e : a * c - b * e;
      vq = j ? b * c - a * e : a * e + b * c;
      ui = rnd(vi, sh);
      uq = rnd(vq, sh);
      r.i = clamp(ui, ob);
      r.q = clamp(uq, ob);
      r.ov = (r.i != ui) || (r.q != uq);
      r.tl = t;
      return r;
   endfunction
   task automatic pop(input int d, input longint i, q, input logic ov, t);
      exp_t e;
      if (sb[d].size() == 0) begin
         chk($sformatf("spurious_out%0d", d), 1, 0);
         return;
      end
      e = sb[d].pop_front();
      chk($sformatf("i_out%0d", d), i, e.i);
      chk($sformatf("q_out%0d", d), q, e.q);
      chk($sformatf("ovf%0d", d), ov, e.ov);
      chk($sformatf("tlast%0d", d), t, e.tl);
   endtask
   // monitor and stimulus capture share one block so pops precede pushes each cycle
   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 3; d++) sb[d].delete();
      end else begin
         chk("tready0", b0.s_axis_tready, !b0.s_axis_tvalid || mr);
         chk("valid_eq1", b1.s_axis_tvalid, b0.s_axis_tvalid);
         chk("valid_eq2", b2.s_axis_tvalid, b0.s_axis_tvalid);
         if (b0.s_axis_tvalid && mr) pop(0, b0.i_out, b0.q_out, b0.ovf, b0.tlast_out);
         if (b1.s_axis_tvalid && mr) pop(1, b1.i_out, b1.q_out, b1.ovf, b1.tlast_out);
         if (b2.s_axis_tvalid && mr) pop(2, b2.i_out, b2.q_out, b2.ovf, b2.tlast_out);
         if (mv && b0.s_axis_tready)
            for (int d = 0; d < 3; d++) sb[d].push_back(model(xi, xq, yi, yq, cj, tl, SH[d], OB[d]));
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic signed [7:0] a, b, c, e, input logic j, t);
      int n = 0;
      logic acc;
      mv = 1'b1; xi = a; xq = b; yi = c; yq = e; cj = j; tl = t;
      do begin
         @(negedge clk);
         acc = b0.s_axis_tready;
         tick;
         n++;
      end while (!acc && n < 100);
      if (!acc) chk("send_timeout", 0, 1);
      mv = 1'b0;
   endtask
   task automatic latency(input string name);
      int n = 0;
      while (!b0.s_axis_tvalid && n < 20) begin
         tick;
         n++;
      end
      chk(name, n, 3);
   endtask
   task automatic send_rand(input logic t);
      send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), t);
   endtask
   initial begin
      checks = 0; passed = 0; done = 1'b0;
      mv = 0; mr = 1; cj = 0; tl = 0; xi = 0; xq = 0; yi = 0; yq = 0; reset = 1;
      repeat (2) tick;
      chk("rst_valid", b0.s_axis_tvalid, 0);
      chk("rst_i", b0.i_out, 0);
      chk("rst_q", b0.q_out, 0);
      chk("rst_ovf", b0.ovf, 0);
      chk("rst_tlast", b0.tlast_out, 0);
      chk("rst_tready", b0.s_axis_tready, 1);
      reset = 0;
      tick;
      send(3, 4, 1, 2, 0, 0);
      latency("latency_first");
      for (int i = 0; i < 6; i++) send(3, 4, 1, 2, 1'(i % 2), 0);
      send(-128, -128, -128, -128, 0, 0);
      send(3, 0, 8, 0, 0, 0);
      send(-3, 0, 8, 0, 0, 0);
      send(127, -128, 127, -128, 1, 0);
      repeat (8) tick;
      fork
         for (int i = 0; i < 20; i++) send_rand(i == 19);
         begin
            repeat (8) tick;
            mr = 0;
            repeat (5) tick;
            mr = 1;
         end
      join
      repeat (10) tick;
      for (int i = 0; i < 3; i++) send_rand(0);
      reset = 1;
      tick;
      chk("rst_mid_valid", b0.s_axis_tvalid, 0);
      chk("rst_mid_i", b0.i_out, 0);
      chk("rst_mid_q", b0.q_out, 0);
      reset = 0;
      repeat (6) tick;
      send(3, 4, 1, 2, 1, 1);
      latency("latency_after_reset");
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               if ($urandom_range(0, 3) == 0) tick;
               send_rand(1'($urandom_range(0, 7) == 0));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               tick;
               mr = $urandom_range(0, 3) != 0;
            end
            mr = 1;
         end
      join
      for (int n = 0; n < 50 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; n++) tick;
      tick;
      chk("drain0", sb[0].size(), 0);
      chk("drain1", sb[1].size(), 0);
      chk("drain2", sb[2].size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end
endmodule
